// File: rtl/queue_pkg.sv
// Shared constants, operation encoding and width helper for the RAM-backed queue.
package queue_pkg;

  localparam int QUEUE_DATA_W = 8;
  localparam int QUEUE_ADDR_W = 10;

  // Accepted-access pattern in one cycle, {write, read}
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } queue_op_e;

  // Occupancy must reach DEPTH itself, hence one bit more than the address
  function automatic int count_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/queue_ram_param_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-first on collision).
module sdp_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_reg [2**ADDR_W];

  // A full queue reads and writes the same slot; the read must see the old word
  always_ff @(posedge clk) begin
    if (we) mem_reg[waddr] <= wdata;
    if (re) rdata <= mem_reg[raddr];
  end

endmodule

// File: rtl/queue_ram_param.sv
// Single-clock FIFO queue on an inferred simple dual-port RAM with registered status flags.
// Define QUEUE_ERR_FLAGS_EN to add the sticky ovf/udf error outputs.
module queue_ram_param
  import queue_pkg::*;
#(
  parameter int DATA_W   = QUEUE_DATA_W,
  parameter int ADDR_W   = QUEUE_ADDR_W,
  parameter int AF_LEVEL = (2**ADDR_W) - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [count_w(ADDR_W)-1:0]  count
`ifdef QUEUE_ERR_FLAGS_EN
  ,
  output logic                        ovf,
  output logic                        udf
`endif
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = count_w(ADDR_W);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              empty_reg, full_reg, af_reg, ae_reg;
  logic              rd_valid_reg;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] ram_q;
  logic              wr_accept, rd_accept;
  queue_op_e         op;

  // Reads only drain stored words; a write may take the slot a same-cycle read frees
  always_comb begin
    rd_accept   = reset_n && rd_en && !empty_reg;
    wr_accept   = reset_n && wr_en && (!full_reg || rd_accept);
    op          = queue_op_e'({wr_accept, rd_accept});
    wr_ptr_next = wr_ptr_reg + ADDR_W'(wr_accept);
    rd_ptr_next = rd_ptr_reg + ADDR_W'(rd_accept);
    count_next  = count_reg;
    case (op)
      OP_WRITE: count_next = count_reg + CNT_W'(1);
      OP_READ:  count_next = count_reg - CNT_W'(1);
      default:  count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      af_reg       <= 1'b0;
      ae_reg       <= 1'b1;
      rd_valid_reg <= 1'b0;
      hold_reg     <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      empty_reg    <= (count_next == '0);
      full_reg     <= (count_next == DEPTH_CNT);
      af_reg       <= (count_next >= AF_CNT);
      ae_reg       <= (count_next <= AE_CNT);
      rd_valid_reg <= rd_accept;
      if (rd_valid_reg) hold_reg <= ram_q;
    end
  end

  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr_reg),
    .wdata (wr_data),
    .re    (rd_accept),
    .raddr (rd_ptr_reg),
    .rdata (ram_q)
  );

  // The RAM output register has no reset, so a resettable copy supplies the held value
  assign rd_data      = rd_valid_reg ? ram_q : hold_reg;
  assign rd_valid     = rd_valid_reg;
  assign empty        = empty_reg;
  assign full         = full_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign count        = count_reg;

`ifdef QUEUE_ERR_FLAGS_EN
  logic ovf_reg, udf_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else begin
      if (wr_en && !wr_accept) ovf_reg <= 1'b1;
      if (rd_en && !rd_accept) udf_reg <= 1'b1;
    end
  end

  assign ovf = ovf_reg;
  assign udf = udf_reg;
`endif

endmodule

// File: tb/tb_queue_ram_param.sv
// Self-checking bench for queue_ram_param: vector table, directed corner sequences and
// randomized push/pop traffic against a queue-based reference model.
module tb_queue_ram_param;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int AF    = DEPTH - 4;
  localparam int AE    = 4;

  logic          clk;
  logic          reset_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty, full, almost_full, almost_empty;
  logic [AW:0]   count;
`ifdef QUEUE_ERR_FLAGS_EN
  logic          ovf, udf;
`endif

  queue_ram_param #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef QUEUE_ERR_FLAGS_EN
    ,
    .ovf          (ovf),
    .udf          (udf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue of words plus the last popped word
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_data;
  bit            m_valid, m_ovf, m_udf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [25:0] dut_status();
    logic e_ovf, e_udf;
`ifdef QUEUE_ERR_FLAGS_EN
    e_ovf = ovf; e_udf = udf;
`else
    e_ovf = 1'b0; e_udf = 1'b0;
`endif
    return {count, empty, full, almost_full, almost_empty, rd_valid, rd_data, e_ovf, e_udf};
  endfunction

  function automatic logic [25:0] model_status();
    int  n;
    logic e_ovf, e_udf;
    n = mq.size();
`ifdef QUEUE_ERR_FLAGS_EN
    e_ovf = m_ovf; e_udf = m_udf;
`else
    e_ovf = 1'b0; e_udf = 1'b0;
`endif
    return {11'(n), n == 0, n == DEPTH, n >= AF, n <= AE, m_valid, m_data, e_ovf, e_udf};
  endfunction

  // Apply one cycle of stimulus, advance the model, then compare at the falling edge
  task automatic step(input bit rn, input bit w, input logic [DW-1:0] d, input bit r);
    int sz;
    bit r_ok, w_ok;
    reset_n = rn; wr_en = w; wr_data = d; rd_en = r;
    if (!rn) begin
      mq.delete();
      m_valid = 0; m_data = '0; m_ovf = 0; m_udf = 0;
    end else begin
      sz   = mq.size();
      r_ok = r && (sz > 0);
      w_ok = w && ((sz < DEPTH) || r_ok);
      m_valid = r_ok;
      if (r_ok) m_data = mq.pop_front();
      if (w_ok) mq.push_back(d);
      if (w && !w_ok) m_ovf = 1;
      if (r && !r_ok) m_udf = 1;
    end
    @(posedge clk);
    @(negedge clk);
    check("cycle_status", 64'(dut_status()), 64'(model_status()));
    reset_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  typedef struct {
    bit            rn, w, r;
    logic [DW-1:0] d;
    int            cnt;
    bit            emp, vld;
    logic [DW-1:0] data;
  } vec_t;

  vec_t tbl[11];
  int   pops;
  int   cyc;
  int   pushed;
  bit   w, r;

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    m_valid = 0; m_data = '0; m_ovf = 0; m_udf = 0;

    //            rn w  r  d       cnt emp vld data
    tbl[0]  = '{0, 0, 0, 8'h00, 0, 1, 0, 8'h00};
    tbl[1]  = '{1, 1, 0, 8'h11, 1, 0, 0, 8'h00};
    tbl[2]  = '{1, 1, 0, 8'h22, 2, 0, 0, 8'h00};
    tbl[3]  = '{1, 0, 1, 8'h00, 1, 0, 1, 8'h11};
    tbl[4]  = '{1, 0, 0, 8'h00, 1, 0, 0, 8'h11};
    tbl[5]  = '{1, 1, 1, 8'h33, 1, 0, 1, 8'h22};
    tbl[6]  = '{1, 0, 1, 8'h00, 0, 1, 1, 8'h33};
    tbl[7]  = '{1, 0, 1, 8'h00, 0, 1, 0, 8'h33};
    tbl[8]  = '{1, 1, 1, 8'h44, 1, 0, 0, 8'h33};
    tbl[9]  = '{1, 0, 1, 8'h00, 0, 1, 1, 8'h44};
    tbl[10] = '{0, 1, 1, 8'h55, 0, 1, 0, 8'h00};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rn, tbl[i].w, tbl[i].d, tbl[i].r);
      check("vec_count", 64'(count), 64'(tbl[i].cnt));
      check("vec_empty_valid", 64'({empty, rd_valid}), 64'({tbl[i].emp, tbl[i].vld}));
      check("vec_rd_data", 64'(rd_data), 64'(tbl[i].data));
      $display("vec %0d: rn=%0d wr=%0d rd=%0d d=%02h -> count=%0d empty=%0d valid=%0d data=%02h",
               i, tbl[i].rn, tbl[i].w, tbl[i].r, tbl[i].d, count, empty, rd_valid, rd_data);
    end

    // 21 words in, idle, 21 out in order
    for (int i = 0; i < 21; i++) step(1, 1, 8'(i + 2), 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 21; i++) begin
      step(1, 0, 0, 1);
      check("seq21_valid", 64'(rd_valid), 64'd1);
      check("seq21_data", 64'(rd_data), 64'(i + 2));
    end
    check("seq21_empty", 64'(empty), 64'd1);
    $display("seq21 done: count=%0d empty=%0d", count, empty);

    // Fill to full, drop an extra write, simultaneous access at full, drain
    for (int i = 0; i < DEPTH; i++) step(1, 1, 8'(i % 128), 0);
    check("fill_count", 64'(count), 64'(DEPTH));
    check("fill_flags", 64'({full, almost_full, empty}), 64'b110);
    step(1, 1, 8'hAA, 0);
    check("ovf_count", 64'(count), 64'(DEPTH));
`ifdef QUEUE_ERR_FLAGS_EN
    check("ovf_flag", 64'(ovf), 64'd1);
`endif
    step(1, 1, 8'h7E, 1);
    check("both_full_count", 64'(count), 64'(DEPTH));
    check("both_full_flag", 64'(full), 64'd1);
    check("both_full_data", 64'(rd_data), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 1);
      check("drain_not_aa", 64'(rd_data == 8'hAA), 64'd0);
    end
    check("drain_empty", 64'(empty), 64'd1);
    $display("fill/drain done: count=%0d empty=%0d", count, empty);

    // Read on empty
    step(1, 0, 0, 1);
    check("udf_valid", 64'(rd_valid), 64'd0);
    check("udf_count", 64'(count), 64'd0);
`ifdef QUEUE_ERR_FLAGS_EN
    check("udf_flag", 64'(udf), 64'd1);
`endif
    $display("read-on-empty done: valid=%0d count=%0d", rd_valid, count);

    // Occupancy 5: simultaneous access, almost_empty boundary, reset at 7
    for (int i = 0; i < 5; i++) step(1, 1, 8'(8'h60 + i), 0);
    check("ae_at5", 64'(almost_empty), 64'd0);
    step(1, 1, 8'h65, 1);
    check("both5_count", 64'(count), 64'd5);
    check("both5_data", 64'(rd_data), 64'h60);
    step(1, 0, 0, 1);
    check("ae_at4", 64'({count, almost_empty}), 64'({11'd4, 1'b1}));
    for (int i = 0; i < 4; i++) step(1, 1, 8'(8'h70 + i), 0);
    check("pre_reset_count", 64'(count), 64'd8);
    step(1, 0, 0, 1);
    check("pre_reset_valid", 64'({count, rd_valid}), 64'({11'd7, 1'b1}));
    step(0, 1, 8'h99, 1);
    check("post_reset", 64'({count, empty, rd_valid, rd_data}), 64'({11'd0, 1'b1, 1'b0, 8'h00}));
    $display("reset-at-7 done: count=%0d empty=%0d valid=%0d", count, empty, rd_valid);

    // Random streaming around occupancy 10 across several pointer wraps
    pops = 0; cyc = 0; pushed = 0;
    while ((pushed < 3000 || mq.size() > 0) && cyc < 20000) begin
      w = (pushed < 3000) && ($urandom_range(0, 9) < ((mq.size() < 10) ? 8 : 3));
      r = $urandom_range(0, 9) < ((mq.size() > 10 || pushed >= 3000) ? 8 : 3);
      if (w) pushed++;
      step(1, w, 8'($urandom), r);
      if (rd_valid) pops++;
      cyc++;
    end
    check("stream_pops", 64'(pops), 64'd3000);
    check("stream_empty", 64'(empty), 64'd1);
    $display("stream done: pushed=%0d popped=%0d cycles=%0d", pushed, pops, cyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
